// File: rtl/wired_bus_arbiter_pkg.sv
// Shared types and constants for the wired-bus arbiter: FSM state encoding,
// hold-counter width and the two legal pull levels of the shared net.
package wired_bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_e;

    localparam int CNT_W = 8;

    localparam logic PULL_LOW  = 1'b0;
    localparam logic PULL_HIGH = 1'b1;

endpackage

// File: rtl/wired_bus_arbiter_if.sv
// Requester-side bundle of the wired-bus arbiter: requests and data in,
// grant, owner and the registered bus value out.
interface wired_bus_arbiter_if #(
    parameter int N = 4,
    parameter int W = 9
) ();

    logic [N-1:0]         req;
    logic [N*W-1:0]       din;
    logic [N-1:0]         gnt;
    logic [$clog2(N)-1:0] owner;
    logic [W-1:0]         bus;
    logic                 bus_valid;
    logic                 busy;
    logic                 timeout;

    modport master (
        input  req, din,
        output gnt, owner, bus, bus_valid, busy, timeout
    );

    modport slave (
        output req, din,
        input  gnt, owner, bus, bus_valid, busy, timeout
    );

endinterface

// File: rtl/wired_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping from N-1 back to 0.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [PW-1:0] idx,
    output logic          any
);

    always_comb begin
        int unsigned j;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        j      = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr) + k) % N;
            if (!any && req[PW'(j)]) begin
                any              = 1'b1;
                idx              = PW'(j);
                onehot[PW'(j)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wired_bus_arbiter.sv
// Round-robin owner sequencer for a shared wired bus with a one-cycle pull-level
// turnaround between owners. Define WIRED_BUS_ARB_TIMEOUT_EN for forced release.
module wired_bus_arbiter
    import wired_bus_arb_pkg::*;
#(
    parameter int   N        = 4,
    parameter int   W        = 9,
    parameter int   MAX_HOLD = 16,
    parameter logic PULL_VAL = PULL_LOW
) (
    input  logic                clk,
    input  logic                rst,
    wired_bus_arbiter_if.master bus_if
);

    localparam int PW = $clog2(N);
    localparam logic [W-1:0] BUS_IDLE = (PULL_VAL == PULL_HIGH) ? '1 : '0;
    // MAX_HOLD only matters in the timeout build; the range check keeps it live in both.
    localparam bit HOLD_FITS = (MAX_HOLD >= 2) && (MAX_HOLD < (1 << CNT_W));

    arb_state_e    state, state_nxt;
    logic [N-1:0]  gnt_q, gnt_nxt;
    logic [PW-1:0] owner_q, owner_nxt;
    logic [PW-1:0] ptr_q, ptr_nxt;
    logic [W-1:0]  bus_q;
    logic          valid_q;
    logic          limit_hit;
    logic          stay;

    logic [N-1:0]  pick_onehot;
    logic [PW-1:0] pick_idx;
    logic          pick_any;

    logic [W-1:0]  din_arr [N];

    for (genvar i = 0; i < N; i++) begin : g_din
        assign din_arr[i] = bus_if.din[i*W +: W];
    end

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req    (bus_if.req),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_q;
        owner_nxt = owner_q;
        ptr_nxt   = ptr_q;
        case (state)
            IDLE, TURN: begin
                if (pick_any) begin
                    state_nxt = GRANT;
                    gnt_nxt   = pick_onehot;
                    owner_nxt = pick_idx;
                    ptr_nxt   = (pick_idx == PW'(N - 1)) ? '0 : pick_idx + 1'b1;
                end else begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (!bus_if.req[owner_q] || limit_hit) begin
                    state_nxt = TURN;
                    gnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    assign stay = (state == GRANT) && (state_nxt == GRANT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            bus_q   <= BUS_IDLE;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            gnt_q   <= gnt_nxt;
            owner_q <= owner_nxt;
            ptr_q   <= ptr_nxt;
            bus_q   <= stay ? din_arr[owner_q] : BUS_IDLE;
            valid_q <= stay;
        end
    end

`ifdef WIRED_BUS_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt;
    logic             timeout_q;

    // Counter reads 0 during the first granted cycle, so the limit is MAX_HOLD-1.
    assign limit_hit = HOLD_FITS && (state == GRANT) &&
                       (hold_cnt == CNT_W'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_cnt  <= stay ? hold_cnt + 1'b1 : '0;
            timeout_q <= limit_hit && bus_if.req[owner_q];
        end
    end

    assign bus_if.timeout = timeout_q;
`else
    assign limit_hit      = 1'b0;
    assign bus_if.timeout = HOLD_FITS & 1'b0;
`endif

    assign bus_if.gnt       = gnt_q;
    assign bus_if.owner     = owner_q;
    assign bus_if.bus       = bus_q;
    assign bus_if.bus_valid = valid_q;
    assign bus_if.busy      = (state != IDLE);

endmodule

// File: tb/tb_wired_bus_arbiter.sv
// Self-checking bench for wired_bus_arbiter: directed scenarios plus random
// request traffic, all compared cycle by cycle against an ownership-level model.
module tb_wired_bus_arbiter;

    localparam int   N        = 4;
    localparam int   W        = 9;
    localparam int   MAX_HOLD = 4;
    localparam logic PULL_VAL = 1'b0;
`ifdef WIRED_BUS_ARB_TIMEOUT_EN
    localparam bit   TO_EN    = 1'b1;
`else
    localparam bit   TO_EN    = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wired_bus_arbiter_if #(.N(N), .W(W)) bif ();

    wired_bus_arbiter #(
        .N        (N),
        .W        (W),
        .MAX_HOLD (MAX_HOLD),
        .PULL_VAL (PULL_VAL)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bif)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: who holds the bus, whether we are in the mandatory gap, and expected outputs.
    bit          m_active = 1'b0;
    bit          m_gap    = 1'b0;
    int          m_owner  = 0;
    int          m_ptr    = 0;
    int          m_held   = 0;
    bit          m_to     = 1'b0;
    bit          m_valid  = 1'b0;
    logic [W-1:0] m_bus   = {W{PULL_VAL}};

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (p + k) % N;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_step(input logic rs, input logic [N-1:0] r, input logic [N*W-1:0] d);
        int w;
        bit forced;
        m_to = 1'b0;
        if (rs) begin
            m_active = 1'b0; m_gap = 1'b0; m_owner = 0; m_ptr = 0; m_held = 0;
            m_bus = {W{PULL_VAL}}; m_valid = 1'b0;
        end else if (m_active) begin
            forced = TO_EN && (m_held >= MAX_HOLD);
            if (r[m_owner] && !forced) begin
                m_bus = d[m_owner*W +: W]; m_valid = 1'b1; m_held++;
            end else begin
                m_active = 1'b0; m_gap = 1'b1; m_to = forced && r[m_owner];
                m_bus = {W{PULL_VAL}}; m_valid = 1'b0;
            end
        end else begin
            w = pick(r, m_ptr);
            m_gap = 1'b0; m_bus = {W{PULL_VAL}}; m_valid = 1'b0;
            if (w >= 0) begin
                m_active = 1'b1; m_owner = w; m_ptr = (w + 1) % N; m_held = 1;
            end
        end
    endtask

    // Observed grant order and all-zero gap lengths between consecutive owners.
    int        grants[$];
    int        gaps[$];
    int        gap_len   = 0;
    bit        seen_gnt  = 1'b0;
    logic [N-1:0] prev_gnt = '0;

    function automatic int onehot_index(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic clear_track();
        grants.delete(); gaps.delete(); gap_len = 0; seen_gnt = 1'b0;
    endtask

    function automatic logic [N*W-1:0] rand_din();
        logic [N*W-1:0] d;
        for (int i = 0; i < N; i++) d[i*W +: W] = W'($urandom);
        return d;
    endfunction

    task automatic cycle(input logic rs, input logic [N-1:0] rq, input logic [N*W-1:0] d);
        logic [N-1:0] eg;
        rst = rs; bif.req = rq; bif.din = d;
        @(posedge clk);
        model_step(rs, rq, d);
        #1;
        eg = m_active ? N'(1 << m_owner) : '0;
        check("gnt",       32'(bif.gnt),       32'(eg));
        check("owner",     32'(bif.owner),     32'(m_owner));
        check("bus",       32'(bif.bus),       32'(m_bus));
        check("bus_valid", 32'(bif.bus_valid), 32'(m_valid));
        check("busy",      32'(bif.busy),      32'(m_active || m_gap));
        check("timeout",   32'(bif.timeout),   32'(m_to));
        if (bif.gnt !== '0 && prev_gnt === '0) begin
            if (seen_gnt) gaps.push_back(gap_len);
            grants.push_back(onehot_index(bif.gnt));
            seen_gnt = 1'b1;
            gap_len  = 0;
        end else if (bif.gnt === '0) begin
            gap_len++;
        end
        prev_gnt = bif.gnt;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, '0, rand_din());
    endtask

    initial begin
        logic [N*W-1:0] d;
        logic [N-1:0]   rq;
        logic [N-1:0]   served;
        int             run0;
        bit             done;

        bif.req = '0;
        bif.din = '0;

        // Reset state
        do_reset(2);
        check("reset_gnt",   32'(bif.gnt),  32'h0);
        check("reset_owner", 32'(bif.owner), 32'h0);
        check("reset_busy",  32'(bif.busy), 32'h0);

        // Single request from requester 2 with fixed data
        for (int i = 0; i < 2; i++) cycle(1'b0, '0, rand_din());
        d = rand_din();
        d[2*W +: W] = 9'h1A5;
        cycle(1'b0, 4'b0100, d);
        check("single_gnt", 32'(bif.gnt), 32'h4);
        check("single_valid_lag", 32'(bif.bus_valid), 32'h0);
        cycle(1'b0, 4'b0100, d);
        check("single_bus", 32'(bif.bus), 32'h1A5);
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0100, d);
        cycle(1'b0, 4'b0000, d);
        check("single_release_bus", 32'(bif.bus), 32'h0);
        check("single_release_busy", 32'(bif.busy), 32'h1);
        cycle(1'b0, 4'b0000, d);
        check("single_idle_busy", 32'(bif.busy), 32'h0);

        // Contention: all request, each drops after 3 granted cycles and re-raises
        do_reset(1);
        clear_track();
        for (int i = 0; i < 24; i++) begin
            rq = '1;
            if (m_active && m_held >= 3) rq[m_owner] = 1'b0;
            cycle(1'b0, rq, rand_din());
        end
        check("cont_count", 32'(grants.size() >= 5), 32'h1);
        for (int i = 0; i < 5; i++)
            check("cont_order", 32'((grants.size() > i) ? grants[i] : -1), 32'(i % N));
        for (int i = 0; i < 4; i++)
            check("cont_gap", 32'((gaps.size() > i) ? gaps[i] : -1), 32'h1);

        // Wrap: after granting 2, requesters 3 and 0 are served in that order
        do_reset(1);
        for (int i = 0; i < 8; i++) begin
            if (m_active && m_owner == 2 && m_held >= 2) break;
            cycle(1'b0, 4'b0100, rand_din());
        end
        clear_track();
        served = '0;
        for (int i = 0; i < 14; i++) begin
            rq = 4'b1001 & ~served;
            if (m_active && m_held >= 2) begin
                rq[m_owner]     = 1'b0;
                served[m_owner] = 1'b1;
            end
            cycle(1'b0, rq, rand_din());
        end
        check("wrap_first",  32'((grants.size() > 0) ? grants[0] : -1), 32'h3);
        check("wrap_second", 32'((grants.size() > 1) ? grants[1] : -1), 32'h0);

        // Reset while requester 1 owns the bus
        do_reset(1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 4'b0010, rand_din());
        check("mid_owner_before", 32'(bif.owner), 32'h1);
        cycle(1'b1, 4'b0011, rand_din());
        check("mid_rst_gnt",   32'(bif.gnt),   32'h0);
        check("mid_rst_owner", 32'(bif.owner), 32'h0);
        check("mid_rst_bus",   32'(bif.bus),   32'(W'({W{PULL_VAL}})));
        cycle(1'b0, 4'b0011, rand_din());
        check("mid_next_gnt", 32'(bif.gnt), 32'h1);

        // Requester 0 stuck high with requester 1 waiting
        do_reset(1);
        run0 = 0;
        done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cycle(1'b0, 4'b0011, rand_din());
            if (!done && bif.gnt[0] === 1'b1) run0++;
            else if (run0 > 0) done = 1'b1;
        end
        check("hold_run0", 32'(run0), TO_EN ? 32'(MAX_HOLD) : 32'd30);

        // Random traffic
        rq = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < N; k++) begin
                if (m_active && m_owner == k)
                    rq[k] = ($urandom_range(0, 5) != 0);
                else if (rq[k])
                    rq[k] = ($urandom_range(0, 9) != 0);
                else
                    rq[k] = ($urandom_range(0, 3) == 0);
            end
            cycle(($urandom_range(0, 249) == 0), rq, rand_din());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wired_bus_arbiter.md
# wired_bus_arbiter

Round-robin arbiter and sequencer for a shared W-bit wired bus with a weak pull value. Grants the bus to one of N requesters, registers the owner's data onto the bus, and forces a one-cycle turnaround with the bus at its pull value between owners so two drivers never overlap. Sits between the requester blocks and the shared net, replacing ad-hoc multi-driver assigns.

## Interface
Parameters:
- N, 4: number of requesters, 2..16
- W, 9: bus width
- MAX_HOLD, 16: maximum consecutive grant cycles when the timeout feature is compiled in, 2..255
- PULL_VAL, 1'b0: idle bus level, replicated to W bits; 0 behaves as pulldown, 1 as pullup

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset; synchronous, active-high
- req  in  N  request per requester; held high while the requester uses the bus
- din  in  N*W  requester data; requester i occupies bits [i*W +: W]
- gnt  out  N  one-hot grant, registered
- owner  out  $clog2(N)  index of the current or most recent grantee
- bus  out  W  registered bus value
- bus_valid  out  1  bus carries owner data rather than the pull value
- busy  out  1  state is GRANT or TURN
- timeout  out  1  one-cycle pulse on forced release

## Operation
- States: IDLE, GRANT, TURN.
- IDLE: if any req is high, go to GRANT and set gnt to the round-robin winner. Otherwise stay in IDLE.
- GRANT:
  - If req[owner] is high and there is no timeout, stay in GRANT.
  - If req[owner] is low, or on timeout, go to TURN with gnt = 0.
- TURN: arbitrate among the current req values. Go to GRANT with the winner, or to IDLE if no req is high.
- Round-robin pointer `ptr`:
  - Search starts at `ptr` and wraps N-1 to 0.
  - On each grant, `ptr` becomes (winner+1) mod N.
  - Reset value is 0, so requester 0 has highest priority after reset.
- Bus register, on every edge:
  - If the state is GRANT and it stays GRANT, bus <= din[owner] and bus_valid <= 1.
  - In all other cases, bus <= {W{PULL_VAL}} and bus_valid <= 0.
- Requests that rise while the bus is owned wait for TURN. There is no pre-emption except by timeout.
- A request is ignored if it rises and falls entirely within a GRANT period of another requester.
- owner holds its last value through TURN and IDLE.

## Timing
- Request to grant: req sampled high at edge t in IDLE gives gnt high after edge t.
- Grant to data: bus_valid rises one edge after gnt rises. bus in the cycle after edge e equals din[owner] sampled at e.
- Release: req[owner] sampled low at edge r gives, after r: gnt = 0, bus = pull, bus_valid = 0, state TURN.
- Handover: the next grant appears after edge r+1. There is always exactly one cycle with all gnt low between owners.
- Simultaneous requests: the round-robin winner takes the bus. Losers keep req high and are served in pointer order.
- A requester that drops and immediately re-raises req loses priority to any other pending requester.
- Reset values, including reset mid-GRANT, take effect at the next edge with rst high:
  - gnt = 0, owner = 0, bus = {W{PULL_VAL}}
  - bus_valid = 0, busy = 0, timeout = 0
  - ptr = 0, state IDLE, hold counter 0
  - No TURN cycle is inserted after reset.

## Configuration
- WIRED_BUS_ARB_TIMEOUT_EN defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each cycle in GRANT.
  - When gnt has been high for MAX_HOLD cycles, the next edge forces TURN and pulses timeout high for one cycle.
  - Because `ptr` already points past the pre-empted requester, it is served last among pending requesters.
- Undefined: no counter logic exists, grants are held indefinitely, and timeout is tied to 0.

## Structure
- Package `wired_bus_arb_pkg` holds:
  - the state enum typedef (IDLE, GRANT, TURN)
  - the counter width constant
  - the PULL_LOW and PULL_HIGH constants
- Sub-module `rr_pick`: a combinational round-robin picker.
  - Inputs: req[N], ptr.
  - Outputs: one-hot winner, winner index, any-valid.
  - Used in both the IDLE and TURN arbitration paths.

## Test plan
- Single request: N=4, PULL_VAL=0; req[2]=1 at edge 5 with din[2]=9'h1A5.
  - gnt=4'b0100 after edge 5.
  - bus=9'h1A5 with bus_valid=1 after edge 6.
  - Drop req at edge 10: bus=9'h000 and gnt=0 after edge 10; IDLE after edge 11.
- Contention: req=4'b1111 held from reset, each requester drops req after 3 grant cycles and re-raises it in its TURN cycle.
  - Grants rotate 0,1,2,3,0.
  - Exactly one all-zero gnt cycle between owners.
  - bus equals PULL_VAL in each gap.
- Wrap: ptr=3 after granting 2, req=4'b1001: requester 3 is granted first, then requester 0.
- Reset mid-GRANT: assert rst for one edge while requester 1 owns the bus with req held high.
  - All outputs return to their reset values.
  - The next grant, one edge after rst falls, goes to requester 0 if req[0]=1.
- Timeout (macro defined, MAX_HOLD=4): req[0] stuck high and req[1]=1.
  - gnt[0] high for exactly 4 cycles, then timeout=1 for one cycle in TURN.
  - gnt=4'b0010 on the following edge.
  - With the macro undefined, gnt[0] never falls.
